// File: rtl/float_pack.sv
// Float format, sequencer state encoding and truncating single-cycle
// arithmetic shared by the LM32 floating-point coprocessor.
package float_pack;

  localparam int Nm = 23;
  localparam int Ne = 8;
  localparam int FW = 1 + Ne + Nm;
  localparam int FLOAT_BIAS = (1 << (Ne - 1)) - 1;

  // Exponents are handled biased in Ne+2 two's-complement bits.
  localparam logic [Ne+1:0] FLOAT_BIAS_X = FLOAT_BIAS[Ne+1:0];
  localparam logic [Ne+1:0] EXP_ONE      = {{(Ne+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    FPU_ADD = 2'b00,
    FPU_SUB = 2'b01,
    FPU_MUL = 2'b10,
    FPU_DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DIV  = 2'b01,
    ST_NORM = 2'b10,
    ST_DONE = 2'b11
  } seq_state_e;

  typedef struct packed {
    logic          sign;
    logic [Ne-1:0] exp;
    logic [Nm-1:0] mant;
  } float;

  function automatic logic float_is_zero(input float f);
    return (f.exp == {Ne{1'b0}}) && (f.mant == {Nm{1'b0}});
  endfunction

  function automatic float float_sat(input logic sign);
    float f_s;
    f_s.sign = sign;
    f_s.exp  = {Ne{1'b1}};
    f_s.mant = {Nm{1'b0}};
    return f_s;
  endfunction

  function automatic float float_zero(input logic sign);
    float f_s;
    f_s.sign = sign;
    f_s.exp  = {Ne{1'b0}};
    f_s.mant = {Nm{1'b0}};
    return f_s;
  endfunction

  function automatic logic [Ne+1:0] exp_ext(input logic [Ne-1:0] e);
    return {2'b00, e};
  endfunction

  // Flush non-positive exponents to signed zero, saturate all-ones and above.
  function automatic float float_make(input logic sign, input logic [Ne+1:0] exp,
                                      input logic [Nm-1:0] mant);
    float f_s;
    if (exp[Ne+1] || (exp == {(Ne+2){1'b0}})) begin
      f_s = float_zero(sign);
    end else if (exp[Ne] || (&exp[Ne-1:0])) begin
      f_s = float_sat(sign);
    end else begin
      f_s.sign = sign;
      f_s.exp  = exp[Ne-1:0];
      f_s.mant = mant;
    end
    return f_s;
  endfunction

  function automatic float float_add(input float a, input float b);
    float          big_s, small_s, res_s;
    logic [Ne-1:0] d_s;
    logic [Nm+1:0] mb_s, ms_s, sum_s;
    logic [Ne+1:0] e_s, lz_s;
    res_s = float_zero(1'b0);
    if (float_is_zero(a)) begin
      res_s = b;
    end else if (float_is_zero(b)) begin
      res_s = a;
    end else begin
      if ({a.exp, a.mant} >= {b.exp, b.mant}) begin
        big_s = a;
        small_s = b;
      end else begin
        big_s = b;
        small_s = a;
      end
      d_s  = big_s.exp - small_s.exp;
      mb_s = {2'b01, big_s.mant};
      ms_s = (d_s > Ne'(Nm + 1)) ? {(Nm+2){1'b0}} : ({2'b01, small_s.mant} >> d_s);
      e_s  = exp_ext(big_s.exp);
      if (big_s.sign == small_s.sign) begin
        sum_s = mb_s + ms_s;
        if (sum_s[Nm+1]) begin
          res_s = float_make(big_s.sign, e_s + EXP_ONE, sum_s[Nm:1]);
        end else begin
          res_s = float_make(big_s.sign, e_s, sum_s[Nm-1:0]);
        end
      end else begin
        sum_s = mb_s - ms_s;
        lz_s  = {(Ne+2){1'b0}};
        for (int i = 0; i <= Nm; i++) begin
          if (sum_s[i]) lz_s = (Ne+2)'(Nm - i);
        end
        if (sum_s == {(Nm+2){1'b0}}) begin
          res_s = float_zero(1'b0);
        end else begin
          sum_s = sum_s << lz_s;
          res_s = float_make(big_s.sign, e_s - lz_s, sum_s[Nm-1:0]);
        end
      end
    end
    return res_s;
  endfunction

  function automatic float float_sub(input float a, input float b);
    float nb_s;
    nb_s = b;
    nb_s.sign = ~b.sign;
    return float_add(a, nb_s);
  endfunction

  function automatic float float_mul(input float a, input float b);
    logic [2*Nm+1:0] prod_s;
    logic [Nm+1:0]   hi_s;
    logic [Ne+1:0]   e_s;
    logic            sign_s;
    float            res_s;
    sign_s = a.sign ^ b.sign;
    prod_s = (2*Nm+2)'({1'b1, a.mant}) * (2*Nm+2)'({1'b1, b.mant});
    hi_s   = (Nm+2)'(prod_s >> Nm);
    e_s    = exp_ext(a.exp) + exp_ext(b.exp) - FLOAT_BIAS_X;
    if (float_is_zero(a) || float_is_zero(b)) begin
      res_s = float_zero(sign_s);
    end else if (hi_s[Nm+1]) begin
      res_s = float_make(sign_s, e_s + EXP_ONE, hi_s[Nm:1]);
    end else begin
      res_s = float_make(sign_s, e_s, hi_s[Nm-1:0]);
    end
    return res_s;
  endfunction

endpackage

// File: rtl/float_div_iter.sv
// Restoring mantissa divider producing Nm+2 quotient bits MSB first; the
// load edge already resolves the first bit, so `done` marks the last step.
module float_div_iter #(
  parameter int Nm = float_pack::Nm
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load,
  input  logic [Nm-1:0] dividend,
  input  logic [Nm-1:0] divisor,
  output logic [Nm+1:0] q,
  output logic          done
);

  localparam int CW = $clog2(Nm + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(Nm + 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  logic [Nm+1:0] rem_r, div_r, q_r;
  logic [CW-1:0] cnt_r;
  logic          active_r;
  logic [Nm+1:0] rem_in_s, div_in_s, rem_next_s;
  logic          bit_s;

  // Select this step's operands and form the compare/subtract/shift result.
  always_comb begin
    if (load) begin
      rem_in_s = {2'b01, dividend};
      div_in_s = {2'b01, divisor};
    end else begin
      rem_in_s = rem_r;
      div_in_s = div_r;
    end
    bit_s = (rem_in_s >= div_in_s);
    if (bit_s) begin
      rem_next_s = (rem_in_s - div_in_s) << 1;
    end else begin
      rem_next_s = rem_in_s << 1;
    end
  end

  // Remainder, divisor, quotient shift register and iteration counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_r    <= {(Nm+2){1'b0}};
      div_r    <= {(Nm+2){1'b0}};
      q_r      <= {(Nm+2){1'b0}};
      cnt_r    <= {CW{1'b0}};
      active_r <= 1'b0;
    end else if (load) begin
      rem_r    <= rem_next_s;
      div_r    <= div_in_s;
      q_r      <= {{(Nm+1){1'b0}}, bit_s};
      cnt_r    <= CNT_ONE;
      active_r <= 1'b1;
    end else if (active_r) begin
      rem_r <= rem_next_s;
      q_r   <= {q_r[Nm:0], bit_s};
      if (cnt_r == CNT_LAST) begin
        cnt_r    <= {CW{1'b0}};
        active_r <= 1'b0;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end else begin
      rem_r <= rem_r;
      q_r   <= q_r;
    end
  end

  assign q    = q_r;
  assign done = active_r && (cnt_r == CNT_LAST);

endmodule

// File: rtl/copro_fpu_seq.sv
// LM32 user-instruction front-end: one-cycle add/sub/mul, iterative divide
// with special-case bypass, and a registered result with completion strobe.
module copro_fpu_seq #(
  parameter int Nm = float_pack::Nm,
  parameter int Ne = float_pack::Ne,
  parameter int FW = 1 + Ne + Nm
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        user_valid,
  input  logic [10:0] user_opcode,
  input  logic [31:0] user_operand_0,
  input  logic [31:0] user_operand_1,
  output logic [31:0] user_result,
  output logic        user_complete,
  output logic        busy
);

  import float_pack::*;

  float          op_a_s, op_b_s, arith_s, special_s, norm_s;
  fpu_op_e       op_s;
  logic          div_sign_s, special_hit_s, div_load_s, div_done_s;
  logic [Nm+1:0] div_q_s;
  logic [Ne+1:0] exp_s;
  logic [Nm-1:0] mant_s;

  seq_state_e    state_r;
  logic          sign_r;
  logic [Ne-1:0] e1_r, e2_r;
  logic [FW-1:0] result_r;
  logic          complete_r, busy_r;

  assign op_a_s     = FW'(user_operand_0);
  assign op_b_s     = FW'(user_operand_1);
  assign op_s       = fpu_op_e'(2'(user_opcode));
  assign div_sign_s = op_a_s.sign ^ op_b_s.sign;

  // Single-cycle arithmetic and divide special-case decode (divisor zero wins).
  always_comb begin
    case (op_s)
      FPU_ADD: arith_s = float_add(op_a_s, op_b_s);
      FPU_SUB: arith_s = float_sub(op_a_s, op_b_s);
      FPU_MUL: arith_s = float_mul(op_a_s, op_b_s);
      default: arith_s = float_zero(1'b0);
    endcase
    special_hit_s = 1'b0;
    special_s     = float_zero(div_sign_s);
    if (float_is_zero(op_b_s)) begin
      special_hit_s = 1'b1;
      special_s     = float_sat(div_sign_s);
    end else if (float_is_zero(op_a_s)) begin
      special_hit_s = 1'b1;
      special_s     = float_zero(div_sign_s);
    end else begin
      special_hit_s = 1'b0;
    end
  end

  assign div_load_s = (state_r == ST_IDLE) && user_valid && (op_s == FPU_DIV) && !special_hit_s;

  float_div_iter #(.Nm(Nm)) u_div (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (div_load_s),
    .dividend (op_a_s.mant),
    .divisor  (op_b_s.mant),
    .q        (div_q_s),
    .done     (div_done_s)
  );

  // Quotient normalisation: a leading zero in Q costs one exponent step.
  always_comb begin
    exp_s = {2'b00, e1_r} - {2'b00, e2_r} + FLOAT_BIAS_X;
    if (div_q_s[Nm+1]) begin
      mant_s = div_q_s[Nm:1];
    end else begin
      mant_s = div_q_s[Nm-1:0];
      exp_s  = exp_s - EXP_ONE;
    end
    norm_s = float_make(sign_r, exp_s, mant_s);
  end

  // Sequencer FSM with registered result, completion strobe and busy flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= ST_IDLE;
      sign_r     <= 1'b0;
      e1_r       <= {Ne{1'b0}};
      e2_r       <= {Ne{1'b0}};
      result_r   <= {FW{1'b0}};
      complete_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      complete_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (user_valid) begin
            busy_r <= 1'b1;
            if (op_s != FPU_DIV) begin
              result_r <= arith_s;
              state_r  <= ST_DONE;
            end else if (special_hit_s) begin
              result_r <= special_s;
              state_r  <= ST_DONE;
            end else begin
              sign_r  <= div_sign_s;
              e1_r    <= op_a_s.exp;
              e2_r    <= op_b_s.exp;
              state_r <= ST_DIV;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_DIV: begin
          if (div_done_s) begin
            state_r <= ST_NORM;
          end else begin
            state_r <= ST_DIV;
          end
        end
        ST_NORM: begin
          result_r <= norm_s;
          state_r  <= ST_DONE;
        end
        ST_DONE: begin
          complete_r <= 1'b1;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign user_result   = 32'(result_r);
  assign user_complete = complete_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_copro_fpu_seq.sv
// Directed-vector bench for copro_fpu_seq: hand-computed results and latencies.
module tb_copro_fpu_seq;

  localparam logic [10:0] OP_ADD = 11'h000;
  localparam logic [10:0] OP_SUB = 11'h001;
  localparam logic [10:0] OP_MUL = 11'h002;
  localparam logic [10:0] OP_DIV = 11'h003;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        user_valid = 1'b0;
  logic [10:0] user_opcode = 11'h000;
  logic [31:0] user_operand_0 = 32'h0;
  logic [31:0] user_operand_1 = 32'h0;
  logic [31:0] user_result;
  logic        user_complete;
  logic        busy;

  int checks_total  = 0;
  int checks_passed = 0;

  copro_fpu_seq dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .user_valid     (user_valid),
    .user_opcode    (user_opcode),
    .user_operand_0 (user_operand_0),
    .user_operand_1 (user_operand_1),
    .user_result    (user_result),
    .user_complete  (user_complete),
    .busy           (busy)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Present one request for exactly one edge (edge 0); returns just after it.
  task automatic start_op(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    user_valid     = 1'b1;
    user_opcode    = opc;
    user_operand_0 = a;
    user_operand_1 = b;
    @(posedge clk_i);
    #1;
    user_valid = 1'b0;
  endtask

  // Count edges until user_complete, bounded; busy must stay high before it.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat     = 0;
    busy_ok = busy;
    while (lat < 60) begin
      @(posedge clk_i);
      #1;
      lat++;
      if (user_complete) break;
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  task automatic run_op(input string tag, input logic [10:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    logic bok;
    start_op(opc, a, b);
    wait_done(lat, bok);
    check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, " result"}, user_result, exp_res);
    check_eq({tag, " busy"}, {31'd0, bok}, 32'd1);
  endtask

  initial begin
    int   lat;
    int   pulses;
    logic bok;

    repeat (2) @(posedge clk_i);
    #1;
    check_eq("reset result", user_result, 32'h0000_0000);
    check_eq("reset complete", {31'd0, user_complete}, 32'd0);
    check_eq("reset busy", {31'd0, busy}, 32'd0);
    rst_i = 1'b0;

    run_op("mul 1.5*2", OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1);
    run_op("add 1+2", OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1);
    run_op("sub 3-1", OP_SUB, 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1);
    run_op("sub 2-2", OP_SUB, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 1);
    run_op("mul -2*0.5 hi opc", 11'h7FE, 32'hC000_0000, 32'h3F00_0000, 32'hBF80_0000, 1);
    run_op("div 6/2", OP_DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);
    run_op("div 1/3", OP_DIV, 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAA, 26);
    run_op("div -6/2", OP_DIV, 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 26);
    run_op("div 1/0", OP_DIV, 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1);
    run_op("div -1/0", OP_DIV, 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1);
    run_op("div 0/0", OP_DIV, 32'h0000_0000, 32'h0000_0000, 32'h7F80_0000, 1);
    run_op("div 0/2", OP_DIV, 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 1);
    run_op("div overflow", OP_DIV, 32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 26);
    run_op("div underflow", OP_DIV, 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 26);

    // A request during DIV must neither restart nor corrupt the division.
    start_op(OP_DIV, 32'h3F80_0000, 32'h4040_0000);
    repeat (5) begin
      @(posedge clk_i);
      #1;
    end
    user_valid     = 1'b1;
    user_opcode    = OP_ADD;
    user_operand_0 = 32'h4000_0000;
    user_operand_1 = 32'h4000_0000;
    @(posedge clk_i);
    #1;
    user_valid = 1'b0;
    wait_done(lat, bok);
    check_eq("ignore latency", 32'(lat + 6), 32'd26);
    check_eq("ignore result", user_result, 32'h3EAA_AAAA);
    @(posedge clk_i);
    #1;
    check_eq("complete pulse", {31'd0, user_complete}, 32'd0);
    check_eq("result hold", user_result, 32'h3EAA_AAAA);

    // Reset in the middle of a division aborts it without a completion.
    start_op(OP_DIV, 32'h40C0_0000, 32'h4000_0000);
    repeat (10) begin
      @(posedge clk_i);
      #1;
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    check_eq("midreset complete", {31'd0, user_complete}, 32'd0);
    check_eq("midreset busy", {31'd0, busy}, 32'd0);
    check_eq("midreset result", user_result, 32'h0000_0000);
    pulses = 0;
    repeat (30) begin
      @(posedge clk_i);
      #1;
      if (user_complete) pulses++;
    end
    check_eq("midreset no complete", 32'(pulses), 32'd0);
    run_op("div 6/2 after reset", OP_DIV, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 26);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
